// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready streaming.
// One input register, log2(WIDTH) prefix levels (optionally registered), and one output register.
module ks_adder_pipe #(
    parameter int WIDTH      = 16,
    parameter int REG_LEVELS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int L = $clog2(WIDTH);

    // g/p are the running group generate/propagate; po keeps the bitwise propagate for the sum.
    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] po;
        logic             c0;
        logic             am;
        logic             bm;
    } stage_t;

    logic adv;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] g_in;
    logic [WIDTH-1:0] p_in;
    logic             c0_in;

    always_comb begin
        b_eff = in_sub ? ~in_b : in_b;
        c0_in = in_sub | in_cin;
        g_in  = in_a & b_eff;
        p_in  = in_a ^ b_eff;
        // Carry-in folded into bit 0 so the prefix tree yields true carries directly.
        g_in[0] = g_in[0] | (p_in[0] & c0_in);
    end

    stage_t s0;

    // NOTE: all pipeline state uses non-blocking assignments so every stage samples
    // its predecessor's pre-edge value; data registers are cleared too so outputs read 0 after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0 <= '0;
        end else if (adv) begin
            s0.valid <= in_valid;
            s0.g     <= g_in;
            s0.p     <= p_in;
            s0.po    <= p_in;
            s0.c0    <= c0_in;
            s0.am    <= in_a[WIDTH-1];
            s0.bm    <= b_eff[WIDTH-1];
        end
    end

    for (genvar k = 0; k < L; k++) begin : g_lvl
        localparam int D = 1 << k;
        stage_t src;
        stage_t nxt;
        stage_t q;

        if (k == 0) begin : g_first
            assign src = s0;
        end else begin : g_next
            assign src = g_lvl[k-1].q;
        end

        always_comb begin
            nxt = src;
            for (int i = D; i < WIDTH; i++) begin
                nxt.g[i] = src.g[i] | (src.p[i] & src.g[i-D]);
                nxt.p[i] = src.p[i] & src.p[i-D];
            end
        end

        if (REG_LEVELS != 0) begin : g_reg
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q <= '0;
                end else if (adv) begin
                    q <= nxt;
                end
            end
        end else begin : g_comb
            assign q = nxt;
        end
    end

    stage_t           last;
    logic [WIDTH-1:0] sum_c;
    logic             ovf_c;
    logic             unused_p;

    assign last     = g_lvl[L-1].q;
    assign sum_c    = last.po ^ {last.g[WIDTH-2:0], last.c0};
    assign ovf_c    = (last.am == last.bm) & (sum_c[WIDTH-1] != last.am);
    assign unused_p = ^last.p;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
            out_zero  <= 1'b0;
        end else if (adv) begin
            out_valid <= last.valid;
            if (last.valid) begin
                out_sum  <= sum_c;
                out_cout <= last.g[WIDTH-1];
                out_ovf  <= ovf_c;
                out_zero <= ~|sum_c;
            end
        end
    end

endmodule
